// File: rtl/snes_pad_pkg.sv
// Shared constants for the SNES controller device: button bit positions,
// frame length, idle pin levels and the parallel-load word builder.
package snes_pad_pkg;

  // Button bit positions within the 12-bit buttons bus (1 = pressed)
  localparam int BTN_B      = 0;
  localparam int BTN_Y      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DN     = 5;
  localparam int BTN_LT     = 6;
  localparam int BTN_RT     = 7;
  localparam int BTN_A      = 8;
  localparam int BTN_X      = 9;
  localparam int BTN_L      = 10;
  localparam int BTN_R      = 11;

  localparam int SNES_BTN_BITS   = 12;
  localparam int SNES_FRAME_BITS = 16;
  localparam int SNES_CNT_W      = 5;

  // Host pins idle with the strobe low and the data clock high
  localparam logic IDLE_STRB = 1'b0;
  localparam logic IDLE_CLK  = 1'b1;

  // Shift register idle content: every bit reads "not pressed"
  localparam logic [SNES_FRAME_BITS-1:0] SR_IDLE = '1;

  // Frame word: four always-released ID bits above the inverted buttons,
  // so bit 0 carries B and a pressed button reads 0 on the wire.
  function automatic logic [SNES_FRAME_BITS-1:0] frame_word(
    input logic [SNES_BTN_BITS-1:0] btn
  );
    return {4'b1111, ~btn};
  endfunction

endpackage

// File: rtl/snes_sync_filter.sv
// Two-flop synchronizer followed by a stability filter. A new level is taken
// only after FILT consecutive samples disagree with the current one; rise and
// fall are registered one-cycle pulses aligned with the level update.
module snes_sync_filter
  import snes_pad_pkg::*;
#(
  parameter int   FILT    = 4,
  parameter logic RST_LVL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic pin_i,
  output logic lvl_o,
  output logic rise_o,
  output logic fall_o
);

  localparam logic [3:0] CNT_MAX = 4'(FILT - 1);

  logic       s1_q, s2_q;
  logic       lvl_q, lvl_d;
  logic [3:0] cnt_q, cnt_d;
  logic       rise_q, rise_d;
  logic       fall_q, fall_d;

  // Metastability guard for the asynchronous host pin
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q <= RST_LVL;
      s2_q <= RST_LVL;
    end else begin
      s1_q <= pin_i;
      s2_q <= s1_q;
    end
  end

  // Count consecutive disagreeing samples; any agreeing sample restarts it
  always_comb begin
    lvl_d  = lvl_q;
    cnt_d  = cnt_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (s2_q == lvl_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      lvl_d  = s2_q;
      cnt_d  = '0;
      rise_d = s2_q;
      fall_d = ~s2_q;
    end else begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  // Filter state and edge pulses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lvl_q  <= RST_LVL;
      cnt_q  <= '0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      lvl_q  <= lvl_d;
      cnt_q  <= cnt_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign lvl_o  = lvl_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/snes_pad_device.sv
// SNES controller emulation: the host strobes to latch the buttons, then
// clocks them out LSB (B) first on joy_data, active low.
// Optional watchdog: define SNES_PAD_WATCHDOG_EN to make host_active track
// strobe activity and to idle the shift register when the host goes quiet.
module snes_pad_device
  import snes_pad_pkg::*;
#(
  parameter int FREQ  = 21_500_000,
  parameter int FILT  = 4,
  parameter int WD_MS = 100
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     joy_strb,
  input  logic                     joy_clk,
  output logic                     joy_data,
  input  logic [SNES_BTN_BITS-1:0] buttons,
  output logic                     frame_done,
  output logic                     host_active
);

  localparam logic [SNES_CNT_W-1:0] CNT_FULL = SNES_CNT_W'(SNES_FRAME_BITS);
  localparam logic [SNES_CNT_W-1:0] CNT_LAST = SNES_CNT_W'(SNES_FRAME_BITS - 1);

  logic strb_lvl, strb_rise, strb_fall;
  logic clk_lvl,  clk_rise,  clk_fall;
  logic unused_pins;
  logic wd_expire;

  logic [SNES_FRAME_BITS-1:0] sr_q, sr_d;
  logic [SNES_CNT_W-1:0]      cnt_q, cnt_d;
  logic                       fd_q, fd_d;

  snes_sync_filter #(.FILT(FILT), .RST_LVL(IDLE_STRB)) u_strb (
    .clk    (clk),
    .reset  (reset),
    .pin_i  (joy_strb),
    .lvl_o  (strb_lvl),
    .rise_o (strb_rise),
    .fall_o (strb_fall)
  );

  snes_sync_filter #(.FILT(FILT), .RST_LVL(IDLE_CLK)) u_clk (
    .clk    (clk),
    .reset  (reset),
    .pin_i  (joy_clk),
    .lvl_o  (clk_lvl),
    .rise_o (clk_rise),
    .fall_o (clk_fall)
  );

  // Falling data-clock edges and the strobe fall carry no meaning here
  assign unused_pins = ^{strb_fall, clk_lvl, clk_fall};

`ifdef SNES_PAD_WATCHDOG_EN
  localparam longint WD_CYC = longint'(WD_MS) * longint'(FREQ) / 64'sd1000;
  localparam int     WD_W   = (WD_CYC < 2) ? 1 : $clog2(WD_CYC + 1);

  logic [WD_W-1:0] wd_q, wd_d;

  // Reload on each accepted strobe, otherwise count down to zero
  always_comb begin
    wd_d      = wd_q;
    wd_expire = 1'b0;
    if (strb_rise) begin
      wd_d = WD_W'(WD_CYC);
    end else if (wd_q != '0) begin
      wd_d      = wd_q - WD_W'(1);
      wd_expire = (wd_q == WD_W'(1));
    end
  end

  // Watchdog count register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) wd_q <= '0;
    else       wd_q <= wd_d;
  end

  assign host_active = (wd_q != '0);
`else
  logic act_q;

  // No watchdog: the host is considered present as soon as reset ends
  always_ff @(posedge clk or posedge reset) begin
    if (reset) act_q <= 1'b0;
    else       act_q <= 1'b1;
  end

  assign host_active = act_q;
  assign wd_expire   = 1'b0;
`endif

  // Load beats shift; an expired watchdog also parks the bit counter so a
  // half-finished frame can never produce a late frame_done.
  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    fd_d  = 1'b0;
    if (strb_lvl) begin
      sr_d  = frame_word(buttons);
      cnt_d = '0;
    end else if (wd_expire) begin
      sr_d  = SR_IDLE;
      cnt_d = CNT_FULL;
    end else if (clk_rise) begin
      sr_d = {1'b0, sr_q[SNES_FRAME_BITS-1:1]};
      if (cnt_q != CNT_FULL) cnt_d = cnt_q + SNES_CNT_W'(1);
      fd_d = (cnt_q == CNT_LAST);
    end
  end

  // Shift register, bit counter and frame_done pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_q  <= SR_IDLE;
      cnt_q <= CNT_FULL;
      fd_q  <= 1'b0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
      fd_q  <= fd_d;
    end
  end

  assign joy_data   = sr_q[0];
  assign frame_done = fd_q;

endmodule

// File: tb/tb_snes_pad_device.sv
// Bench for snes_pad_device: a host driver issues strobes and data clocks and
// pushes the expected reading of each sample into a queue; a monitor on the
// falling clk edge pops and compares against the DUT outputs.
module tb_snes_pad_device;

  logic        clk = 1'b0;
  logic        reset;
  logic        joy_strb;
  logic        joy_clk;
  logic        joy_data;
  logic [11:0] buttons;
  logic        frame_done;
  logic        host_active;

  // 1 MHz clock so one cycle is one microsecond of host timing
  always #500 clk = ~clk;

  snes_pad_device #(.FREQ(1_000_000), .FILT(4), .WD_MS(1)) dut (
    .clk         (clk),
    .reset       (reset),
    .joy_strb    (joy_strb),
    .joy_clk     (joy_clk),
    .joy_data    (joy_data),
    .buttons     (buttons),
    .frame_done  (frame_done),
    .host_active (host_active)
  );

  // kind: 0 joy_data, 1 frame_done pulse total, 2 host_active, 3 frame_done level
  typedef struct {
    int kind;
    int exp;
  } chk_t;

  chk_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   fd_seen = 0;

  // Reference model: the latched frame word, how many bits the host has
  // clocked since it, whether a frame_done is still owed, and pulses owed so far
  logic [15:0] m_word;
  int          m_pos;
  bit          m_live;
  int          m_fd;

  function automatic int m_bit();
    if (m_pos < 16) return int'(m_word[m_pos]);
    return 0;
  endfunction

  task automatic push(input int kind, input int exp);
    chk_t c;
    c.kind = kind;
    c.exp  = exp;
    q.push_back(c);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #137;
  endtask

  task automatic model_idle();
    m_word = 16'hFFFF;
    m_pos  = 0;
    m_live = 1'b0;
  endtask

  task automatic strobe(input logic [11:0] b);
    buttons  = b;
    joy_strb = 1'b1;
    wait_cyc(12);
    joy_strb = 1'b0;
    m_word   = {4'hF, ~b};
    m_pos    = 0;
    m_live   = 1'b1;
    wait_cyc(10);
    buttons  = 12'($urandom);
    push(0, m_bit());
  endtask

  task automatic hclk();
    joy_clk = 1'b0;
    wait_cyc(10);
    joy_clk = 1'b1;
    wait_cyc(10);
    if (m_pos < 100) m_pos++;
    if (m_live && m_pos == 16) begin
      m_fd++;
      m_live = 1'b0;
    end
    push(0, m_bit());
  endtask

  // Too short to pass the filter: nothing may move
  task automatic glitch();
    joy_clk = 1'b0;
    wait_cyc(2);
    joy_clk = 1'b1;
    wait_cyc(10);
    push(0, m_bit());
  endtask

  // Monitor: count frame_done pulses, then settle every queued expectation
  initial begin
    chk_t  c;
    int    act;
    string nm;
    forever begin
      @(negedge clk);
      if (frame_done) fd_seen++;
      while (q.size() > 0) begin
        c = q.pop_front();
        case (c.kind)
          0:       begin act = int'(joy_data);    nm = "joy_data";    end
          1:       begin act = fd_seen;           nm = "frame_count"; end
          2:       begin act = int'(host_active); nm = "host_active"; end
          default: begin act = int'(frame_done);  nm = "frame_done";  end
        endcase
        n_tests++;
        if (act != c.exp) begin
          n_fail++;
          $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, c.exp);
        end
      end
    end
  end

  // Hard stop in case the stimulus never completes
  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL timeout: stimulus did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    reset    = 1'b1;
    joy_strb = 1'b0;
    joy_clk  = 1'b1;
    buttons  = '0;
    m_fd     = 0;
    model_idle();

    // Reset state
    wait_cyc(3);
    push(0, 1);
    push(2, 0);
    push(3, 0);
    wait_cyc(2);
    reset = 1'b0;
    wait_cyc(3);
`ifdef SNES_PAD_WATCHDOG_EN
    push(2, 0);
`else
    push(2, 1);
`endif

    // Only B pressed: 0 then fifteen 1s, one frame_done
    strobe(12'h001);
    repeat (16) hclk();
    push(1, m_fd);

    // All pressed: twelve 0s, four 1s, and a 17th clock reads 0
    strobe(12'hFFF);
    repeat (17) hclk();
    push(1, m_fd);

    // Mid-frame strobe aborts without a frame_done; 12th bit of R is 0
    strobe(12'h800);
    repeat (5) hclk();
    strobe(12'h800);
    repeat (11) hclk();
    push(1, m_fd);
    repeat (5) hclk();
    push(1, m_fd);

    // Short glitches on joy_clk must not shift or count
    strobe(12'($urandom));
    repeat (3) hclk();
    glitch();
    glitch();
    repeat (13) hclk();
    push(1, m_fd);

    // Reset in the middle of the 8th bit
    strobe(12'($urandom));
    repeat (7) hclk();
    joy_clk = 1'b0;
    wait_cyc(5);
    reset = 1'b1;
    model_idle();
    push(0, 1);
    joy_clk = 1'b1;
    wait_cyc(3);
    reset = 1'b0;
    wait_cyc(10);
    push(0, m_bit());
    repeat (2) hclk();
    push(1, m_fd);
    strobe(12'($urandom));
    repeat (16) hclk();
    push(1, m_fd);

    // Random frames with random lengths, aborts and glitches
    for (int f = 0; f < 10; f++) begin
      strobe(12'($urandom));
      n = $urandom_range(0, 20);
      for (int k = 0; k < n; k++) begin
        if ($urandom_range(0, 5) == 0) glitch();
        hclk();
      end
      push(1, m_fd);
    end

`ifdef SNES_PAD_WATCHDOG_EN
    // Host goes quiet for longer than 1 ms, then strobes again
    strobe(12'h0F0);
    wait_cyc(960);
    push(2, 1);
    wait_cyc(60);
    model_idle();
    push(2, 0);
    push(0, m_bit());
    strobe(12'h0F0);
    push(2, 1);
`endif

    wait_cyc(3);
    if (q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
